// File: rtl/b_id_pkg.sv
// -----------------------------------------------------------------------------
// b_id_pkg
// Shared definitions for the B-channel ID restorer:
//   - default ID_PAD / ID_WIDTH values
//   - BRESP encodings
//   - extended response ID layout {seq, id} at the default widths
// -----------------------------------------------------------------------------
package b_id_pkg;

  localparam int unsigned ID_PAD_DEFAULT   = 4;
  localparam int unsigned ID_WIDTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;

  // Extended BID as returned by the slave: sequence tag above the original ID.
  typedef struct packed {
    logic [ID_PAD_DEFAULT-1:0]   seq;
    logic [ID_WIDTH_DEFAULT-1:0] id;
  } ext_id_t;

endpackage

// File: rtl/b_skid_buffer.sv
// -----------------------------------------------------------------------------
// b_skid_buffer
// Two-entry registered skid buffer. A beat accepted on the input appears on
// the output the following cycle; one beat per cycle is sustained. in_ready_o
// is a register that drops only while both entries are occupied. Output
// valid/data hold until out_ready_i.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i    upstream handshake + payload
//   out_valid_o/out_ready_i/out_data_o downstream handshake + payload
// -----------------------------------------------------------------------------
module b_skid_buffer #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              push_s, pop_s;

  assign push_s = in_valid_i & ready_q;
  assign pop_s  = out_ready_i & (cnt_q != 2'd0);

  // Next-state for storage, pointers, occupancy and registered ready.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    // Ready is computed from next occupancy so it can be registered.
    ready_d = (cnt_d != 2'd2);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/b_id_restorer.sv
// -----------------------------------------------------------------------------
// b_id_restorer
// Tracks outstanding writes per original ID lane, strips the sequence tag
// from returning B responses and forwards them through a 2-entry skid buffer.
// Optional feature macro: B_ID_SEQ_CHECK_EN -- when defined, each lane keeps
// an expected sequence tag and raises a sticky ERR_SEQ bit on mismatch; when
// undefined ERR_SEQ is tied to zero.
// Ports:
//   Aclk, ARESETRst              clock, synchronous active-high reset
//   AW_ID, AW_valid, AW_Ready    write-address issue; AW_allow gates the lane
//   S_BID/S_BRESP/S_BVALID/S_BREADY  slave-side response, S_BID = {seq, id}
//   M_BID/M_BRESP/M_BVALID/M_BREADY  master-side response with restored ID
//   ERR_SEQ                      sticky per-lane sequence mismatch
//   ERR_ORPHAN                   sticky response-with-nothing-outstanding
// -----------------------------------------------------------------------------
module b_id_restorer
  import b_id_pkg::*;
#(
  parameter int unsigned ID_PAD   = ID_PAD_DEFAULT,
  parameter int unsigned ID_WIDTH = ID_WIDTH_DEFAULT
) (
  input  logic                       Aclk,
  input  logic                       ARESETRst,
  input  logic [ID_WIDTH-1:0]        AW_ID,
  input  logic                       AW_valid,
  input  logic                       AW_Ready,
  output logic                       AW_allow,
  input  logic [ID_WIDTH+ID_PAD-1:0] S_BID,
  input  logic [1:0]                 S_BRESP,
  input  logic                       S_BVALID,
  output logic                       S_BREADY,
  output logic [ID_WIDTH-1:0]        M_BID,
  output logic [1:0]                 M_BRESP,
  output logic                       M_BVALID,
  input  logic                       M_BREADY,
  output logic [(1<<ID_WIDTH)-1:0]   ERR_SEQ,
  output logic                       ERR_ORPHAN
);

  localparam int unsigned LANES = 1 << ID_WIDTH;
  localparam int unsigned CW    = ID_PAD + 1;
  localparam int unsigned PW    = ID_WIDTH + 2;
  // A lane is full once every sequence tag value is in flight.
  localparam logic [CW-1:0] CNT_FULL = {1'b1, {ID_PAD{1'b0}}};

  logic [CW-1:0]       cnt_q [LANES];
  logic [CW-1:0]       cnt_d [LANES];
  logic [LANES-1:0]    inc_s, dec_s;
  logic                err_orphan_q, err_orphan_d;
  logic                aw_fire_s, b_acc_s, b_orphan_s;
  logic [ID_WIDTH-1:0] b_lane_s;
  logic [ID_PAD-1:0]   b_seq_s;
  logic                s_bready_s;
  logic [PW-1:0]       skid_out_s;

  assign b_lane_s   = S_BID[ID_WIDTH-1:0];
  assign b_seq_s    = S_BID[ID_WIDTH+ID_PAD-1:ID_WIDTH];
  assign AW_allow   = (cnt_q[AW_ID] != CNT_FULL);
  assign aw_fire_s  = AW_valid & AW_Ready & AW_allow;
  assign b_acc_s    = S_BVALID & s_bready_s;
  assign b_orphan_s = b_acc_s & (cnt_q[b_lane_s] == '0);

  // Per-lane outstanding counters; a decrement is suppressed at zero.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      inc_s[l] = aw_fire_s && (AW_ID == ID_WIDTH'(l));
      dec_s[l] = b_acc_s && (b_lane_s == ID_WIDTH'(l)) && (cnt_q[l] != '0);
      if (inc_s[l] && !dec_s[l]) begin
        cnt_d[l] = cnt_q[l] + CW'(1);
      end else if (dec_s[l] && !inc_s[l]) begin
        cnt_d[l] = cnt_q[l] - CW'(1);
      end else begin
        cnt_d[l] = cnt_q[l];
      end
    end
    err_orphan_d = err_orphan_q | b_orphan_s;
  end

  // Counter and orphan-flag registers.
  always_ff @(posedge Aclk) begin
    if (ARESETRst) begin
      for (int l = 0; l < LANES; l++) begin
        cnt_q[l] <= '0;
      end
      err_orphan_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign ERR_ORPHAN = err_orphan_q;

`ifdef B_ID_SEQ_CHECK_EN
  logic [ID_PAD-1:0] exp_q [LANES];
  logic [ID_PAD-1:0] exp_d [LANES];
  logic [LANES-1:0]  err_seq_q, err_seq_d;

  // Expected-tag tracking; after any accept the lane expects received tag + 1,
  // which both advances on a match and resynchronises after a mismatch.
  always_comb begin
    exp_d     = exp_q;
    err_seq_d = err_seq_q;
    if (b_acc_s) begin
      exp_d[b_lane_s] = b_seq_s + ID_PAD'(1);
      if (b_seq_s != exp_q[b_lane_s]) begin
        err_seq_d[b_lane_s] = 1'b1;
      end else begin
        err_seq_d[b_lane_s] = err_seq_q[b_lane_s];
      end
    end else begin
      exp_d = exp_q;
    end
  end

  // Expected-tag and sticky mismatch registers.
  always_ff @(posedge Aclk) begin
    if (ARESETRst) begin
      for (int l = 0; l < LANES; l++) begin
        exp_q[l] <= '0;
      end
      err_seq_q <= '0;
    end else begin
      exp_q     <= exp_d;
      err_seq_q <= err_seq_d;
    end
  end

  assign ERR_SEQ = err_seq_q;
`else
  logic unused_seq_s;
  assign unused_seq_s = ^b_seq_s;
  assign ERR_SEQ      = '0;
`endif

  b_skid_buffer #(
    .DATA_W (PW)
  ) u_skid (
    .clk_i       (Aclk),
    .rst_i       (ARESETRst),
    .in_valid_i  (S_BVALID),
    .in_ready_o  (s_bready_s),
    .in_data_i   ({b_lane_s, S_BRESP}),
    .out_valid_o (M_BVALID),
    .out_ready_i (M_BREADY),
    .out_data_o  (skid_out_s)
  );

  assign S_BREADY = s_bready_s;
  assign M_BID    = skid_out_s[PW-1:2];
  assign M_BRESP  = skid_out_s[1:0];

endmodule

// File: doc/b_id_restorer.md
B_ID_RESTORER -- requirements
Module: b_id_restorer

Interface
REQ-001 Parameter ID_PAD, default 4: width of the per-ID sequence tag carried in the upper BID bits.
REQ-002 Parameter ID_WIDTH, default 2: width of the original master ID; 2^ID_WIDTH independent ID lanes.
REQ-003 Aclk  input  1  single clock; all logic rising-edge.
REQ-004 ARESETRst  input  1  reset, synchronous, active-high.
REQ-005 AW_ID  input  ID_WIDTH  original ID of the write address being issued.
REQ-006 AW_valid  input  1  write address valid at the master-facing side.
REQ-007 AW_Ready  input  1  downstream write address ready.
REQ-008 AW_allow  output  1  high when the lane selected by AW_ID may accept another address.
REQ-009 S_BID  input  ID_WIDTH+ID_PAD  extended response ID: {seq, id}.
REQ-010 S_BRESP  input  2  slave write response.
REQ-011 S_BVALID  input  1  slave response valid.
REQ-012 S_BREADY  output  1  ready to slave.
REQ-013 M_BID  output  ID_WIDTH  restored original ID.
REQ-014 M_BRESP  output  2  forwarded response.
REQ-015 M_BVALID  output  1  response valid to master.
REQ-016 M_BREADY  input  1  master ready.
REQ-017 ERR_SEQ  output  2^ID_WIDTH  sticky per-lane sequence-mismatch flags.
REQ-018 ERR_ORPHAN  output  1  sticky flag: response for a lane with zero outstanding writes.

Function
REQ-019 AW fire = AW_valid & AW_Ready & AW_allow; each fire increments outstanding[AW_ID].
REQ-020 B accept = S_BVALID & S_BREADY; each accept decrements outstanding[S_BID[ID_WIDTH-1:0]].
REQ-021 Same-cycle AW fire and B accept on the same lane leave that lane's count unchanged; on different lanes, both update.
REQ-022 Outstanding counters are ID_PAD+1 bits; AW_allow is low when outstanding[AW_ID] == 2^ID_PAD, so a sequence tag is never reused while outstanding.
REQ-023 The B path is a 2-entry skid buffer: latency 1 cycle from B accept to M_BVALID; one response per cycle sustained; S_BREADY registered, low only when both entries are full.
REQ-024 M_BID = S_BID[ID_WIDTH-1:0] of the buffered entry; S_BRESP is forwarded unchanged; responses are delivered in acceptance order.
REQ-025 M_BVALID holds, and M_BID/M_BRESP stay stable, until M_BREADY is high.
REQ-026 Per lane, expected_seq (ID_PAD bits) is compared with S_BID[ID_WIDTH+ID_PAD-1:ID_WIDTH] on B accept and increments on accept, wrapping 2^ID_PAD-1 -> 0.
REQ-027 A mismatch sets ERR_SEQ[lane] the cycle after the accept; the response is still forwarded and expected_seq resynchronises to received seq+1.
REQ-028 B accept on a lane with outstanding == 0 sets ERR_ORPHAN, forwards the response and leaves the counter at 0 (no underflow).

Reset
REQ-029 While ARESETRst is high at a clock edge, all of the following clear: outstanding counters, expected_seq, skid entries, M_BVALID, ERR_SEQ and ERR_ORPHAN (all 0); S_BREADY 0; M_BID/M_BRESP 0.
REQ-030 S_BREADY rises the first cycle after reset deasserts; a reset asserted mid-transfer discards buffered responses.

Configuration
REQ-031 Macro B_ID_SEQ_CHECK_EN defined: REQ-026..REQ-027 are implemented.
REQ-032 Macro undefined: expected_seq registers are absent, ERR_SEQ is tied to 0; ERR_ORPHAN, the counters and the data path are unaffected.

Structure
REQ-033 Package b_id_pkg holds the default ID_PAD and ID_WIDTH, the BRESP encodings (OKAY, EXOKAY, SLVERR, DECERR) and a typedef for the extended-ID structure {seq, id}.
REQ-034 A single sub-module, b_skid_buffer, parameterised on payload width, implements REQ-023/REQ-025.

Verification
REQ-035 Reset, then 3 AW fires on ID 1, then responses with S_BID seq 0, 1, 2 -> M_BID = 1 each, 1 cycle latency, outstanding[1] returns to 0, no error flags.
REQ-036 Hold M_BREADY = 0 while sending 3 back-to-back responses -> S_BREADY falls after the 2nd accept; after M_BREADY rises, all 3 are delivered in order, with no loss or duplication.
REQ-037 16 AW fires on ID 2 with no responses -> AW_allow is low for AW_ID = 2 and high for AW_ID = 0; one response, then AW_allow for ID 2 is high the next cycle.
REQ-038 Expected seq 3 on ID 0 and a received response with seq 5 -> ERR_SEQ[0] = 1 the next cycle, the response is forwarded, and a following response with seq 6 raises no new error (flag stays sticky).
REQ-039 A response on ID 3 with zero outstanding -> ERR_ORPHAN = 1, outstanding[3] stays 0; same-cycle AW fire and response on ID 1 -> count unchanged.
REQ-040 Wrap: 17 sequential write/response pairs on ID 0 -> seq 15 is followed by seq 0 and no error is raised; assert reset with 1 buffered response -> M_BVALID = 0 the next cycle.
